// File: rtl/booth_seq_mul_ctrl.sv
// Iterative radix-2 Booth signed multiplier sequencer for the FIR MAC path.
// One operand pair per input handshake, WIDTH add/sub/shift steps, product on an output handshake.
module booth_seq_mul_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH:0]     r_acc;
    logic [WIDTH-1:0]   r_q;
    logic               r_q_m1;
    logic [WIDTH:0]     r_m;
    logic [CW-1:0]      r_cnt;

    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;
    logic [2*WIDTH-1:0] r_product;

    logic               w_accept;
    logic               w_last;
    logic               w_add_en;
    logic               w_sub;
    logic [WIDTH:0]     w_sel_m;
    logic [WIDTH:0]     w_addend;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_acc_sh;
    logic [WIDTH-1:0]   w_q_sh;

    // Booth recoding of {Q[0], q_m1}: returns {add_enable, subtract}.
    function automatic logic [1:0] booth_decode(input logic [1:0] pair);
        logic [1:0] d;
        case (pair)
            2'b01:   d = 2'b10;
            2'b10:   d = 2'b11;
            default: d = 2'b00;
        endcase
        return d;
    endfunction

    assign w_accept = in_valid && r_in_ready;
    assign w_last   = (r_state == ST_RUN) && (r_cnt == CNT_ONE);

    // Booth step datapath: operand-select mux, add/sub, arithmetic right shift.
    always_comb begin
        {w_add_en, w_sub} = booth_decode({r_q[0], r_q_m1});
        // Subtraction is ~M plus a carry-in, so only one adder is needed.
        w_sel_m  = w_sub    ? ~r_m    : r_m;
        w_addend = w_add_en ? w_sel_m : {(WIDTH+1){1'b0}};
        w_sum    = r_acc + w_addend + {{WIDTH{1'b0}}, w_sub};
        w_acc_sh = {w_sum[WIDTH], w_sum[WIDTH:1]};
        w_q_sh   = {w_sum[0], r_q[WIDTH-1:1]};
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (r_cnt == CNT_ONE) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand load and per-step update of {A, Q, q_m1} and the step counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc  <= {(WIDTH+1){1'b0}};
            r_q    <= {WIDTH{1'b0}};
            r_q_m1 <= 1'b0;
            r_m    <= {(WIDTH+1){1'b0}};
            r_cnt  <= {CW{1'b0}};
        end else if (w_accept) begin
            r_acc  <= {(WIDTH+1){1'b0}};
            r_q    <= mplier;
            r_q_m1 <= 1'b0;
            r_m    <= {mcand[WIDTH-1], mcand};
            r_cnt  <= CNT_INIT;
        end else if (r_state == ST_RUN) begin
            r_acc  <= w_acc_sh;
            r_q    <= w_q_sh;
            r_q_m1 <= r_q[0];
            r_cnt  <= r_cnt - CNT_ONE;
        end
    end

    // Product is captured from the final step and held until the next result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_product <= {(2*WIDTH){1'b0}};
        end else if (w_last) begin
            r_product <= {w_acc_sh[WIDTH-1:0], w_q_sh};
        end
    end

    // Handshake/status outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == ST_IDLE);
            r_out_valid <= (w_state_nxt == ST_DONE);
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign product   = r_product;

endmodule
